mipi_raw10_packer: RTL

- Transmit-side counterpart of the CSI-2 RAW10 unpacker.
- Accepts groups of four 10-bit pixels.
- Packs each group into the 5-byte CSI-2 RAW10 format.
- Emits a 32-bit little-endian word stream with valid/ready handshakes on both sides. It sits between the ISP pixel pipeline and the CSI-2 TX lane distributor / Wishbone readback path.
- Flushes a zero-padded partial word at end of line and reports the word count of each line.

---
 rtl/mipi_raw10_packer.sv | 64 ++++++
 1 files changed

// File: rtl/mipi_raw10_packer.sv
// mipi_raw10_packer: packs 4x10-bit pixel groups into CSI-2 RAW10 bytes, emitted as 32-bit LE words per line
module mipi_raw10_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [39:0]      in_pix_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic [3:0]       out_keep_o,
  output logic             out_last_o,
  output logic [CNT_W-1:0] line_words_o,
  output logic             line_done_o
);
  logic [63:0]      buf_q, buf_d, shifted;
  logic [3:0]       cnt_q, cnt_d, popped, rem;
  logic             last_pend_q, in_fire, out_fire;
  logic [39:0]      grp;
  logic [CNT_W-1:0] wcnt_q, wsat;
  assign grp = {in_pix_i[31:30], in_pix_i[21:20], in_pix_i[11:10], in_pix_i[1:0],
                in_pix_i[39:32], in_pix_i[29:22], in_pix_i[19:12], in_pix_i[9:2]};
  assign out_valid_o = (cnt_q >= 4'd4) || (last_pend_q && cnt_q != 4'd0);
  assign out_last_o  = out_valid_o && last_pend_q && cnt_q <= 4'd4;
  assign out_keep_o  = cnt_q >= 4'd4 ? 4'hF : (4'd1 << cnt_q[1:0]) - 4'd1;
  assign in_ready_o  = !last_pend_q && (cnt_q <= 4'd3 || (cnt_q <= 4'd7 && out_ready_i));
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign wsat        = &wcnt_q ? wcnt_q : wcnt_q + 1'b1;
  // Bytes at or above cnt are kept zero, so appending is a plain OR at the fill point.
  always_comb begin
    popped  = out_fire ? (cnt_q >= 4'd4 ? 4'd4 : cnt_q) : 4'd0;
    shifted = buf_q >> {popped, 3'b000};
    rem     = cnt_q - popped;
    buf_d   = in_fire ? shifted | ({24'b0, grp} << {rem, 3'b000}) : shifted;
    cnt_d   = rem + (in_fire ? 4'd5 : 4'd0);
    out_data_o = '0;
    for (int k = 0; k < 4; k++)
      out_data_o[8*k +: 8] = !out_valid_o ? 8'h00 : (4'(k) < cnt_q ? buf_q[8*k +: 8] : PAD_BYTE);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      last_pend_q  <= 1'b0;
      wcnt_q       <= '0;
      line_words_o <= '0;
      line_done_o  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      line_done_o <= out_fire && out_last_o;
      last_pend_q <= (in_fire && in_last_i) ? 1'b1 : (out_fire && out_last_o) ? 1'b0 : last_pend_q;
      if (out_fire) begin
        wcnt_q <= out_last_o ? '0 : wsat;
        if (out_last_o) line_words_o <= wsat;
      end
    end
  end
endmodule
